// File: rtl/frame_cnt_pkg.sv
// Shared definitions for the frame bit counter: state encoding and framing mode constants.
package frame_cnt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  localparam int MODE_ONESHOT = 0;
  localparam int MODE_CONT    = 1;

endpackage

// File: rtl/frame_bit_counter.sv
// Programmable-length shift/bit counter for the UART datapaths, one-shot or continuous framing.
// Optional sticky start-during-RUN error flag enabled by defining FRAME_BIT_COUNTER_OVERRUN_EN.
module frame_bit_counter
  import frame_cnt_pkg::*;
#(
  parameter int N    = 4,
  parameter int WRAP = MODE_ONESHOT
) (
  input  logic         inClk,
  input  logic         rst,
  input  logic         start,
  input  logic         ena,
  input  logic         clr,
  input  logic [N-1:0] len,
  output logic [N-1:0] out,
  output logic         busy,
  output logic         done,
`ifdef FRAME_BIT_COUNTER_OVERRUN_EN
  output logic         overrun,
`endif
  output logic         tc
);

  localparam logic [N-1:0] ONE = N'(1);

  state_t       r_state;
  logic [N-1:0] r_out;
  logic [N-1:0] r_len_q;
  logic         r_busy;
  logic         r_done;

  logic [N-1:0] w_last;
  logic         w_at_last;
  logic         w_start_ok;

  // lenQ-1 wraps when lenQ==0, but that value is only ever compared while RUN, where lenQ>=1.
  assign w_last     = r_len_q - ONE;
  assign w_at_last  = (r_out == w_last);
  assign w_start_ok = start && (len != '0);

  // NOTE: tc is the one combinational output; it must be high in the same cycle as the final ena.
  assign tc = r_busy & ena & w_at_last;

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge inClk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_len_q <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else if (clr) begin
      r_state <= ST_IDLE;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_done <= 1'b0;
          if (w_start_ok) begin
            r_len_q <= len;
            r_out   <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end

        ST_RUN: begin
          if (ena) begin
            if (w_at_last) begin
              r_out   <= r_len_q;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
              r_state <= ST_DONE;
            end else begin
              r_out <= r_out + ONE;
            end
          end
        end

        ST_DONE: begin
          r_done <= 1'b0;
          r_out  <= '0;
          if (WRAP == MODE_CONT) begin
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else if (w_start_ok) begin
            // Back-to-back frame: no idle cycle between frames.
            r_len_q <= len;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end else begin
            r_busy  <= 1'b0;
            r_state <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_out   <= '0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

`ifdef FRAME_BIT_COUNTER_OVERRUN_EN
  logic r_overrun;

  always_ff @(posedge inClk or posedge rst) begin
    if (rst) begin
      r_overrun <= 1'b0;
    end else if (clr) begin
      r_overrun <= 1'b0;
    end else if (start && (r_state == ST_RUN)) begin
      r_overrun <= 1'b1;
    end
  end

  assign overrun = r_overrun;
`endif

  assign out  = r_out;
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_frame_bit_counter.sv
// Bench for frame_bit_counter: one-shot and continuous instances share stimulus and are checked every cycle.
module tb_frame_bit_counter;

  localparam int N = 4;

  logic         clk   = 1'b0;
  logic         rst   = 1'b1;
  logic         start = 1'b0;
  logic         ena   = 1'b0;
  logic         clr   = 1'b0;
  logic [N-1:0] len   = '0;

  logic [N-1:0] out0, out1;
  logic         busy0, busy1, done0, done1, tc0, tc1;
`ifdef FRAME_BIT_COUNTER_OVERRUN_EN
  logic         ovr0, ovr1;
`endif

  int n_checks = 0;
  int n_errors = 0;

  frame_bit_counter #(.N(N), .WRAP(0)) dut0 (
    .inClk(clk), .rst(rst), .start(start), .ena(ena), .clr(clr), .len(len),
    .out(out0), .busy(busy0), .done(done0),
`ifdef FRAME_BIT_COUNTER_OVERRUN_EN
    .overrun(ovr0),
`endif
    .tc(tc0)
  );

  frame_bit_counter #(.N(N), .WRAP(1)) dut1 (
    .inClk(clk), .rst(rst), .start(start), .ena(ena), .clr(clr), .len(len),
    .out(out1), .busy(busy1), .done(done1),
`ifdef FRAME_BIT_COUNTER_OVERRUN_EN
    .overrun(ovr1),
`endif
    .tc(tc1)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Frame model: a frame is "ena events still to go"; out is simply len minus that.
  bit m_run [2];
  bit m_done[2];
  bit m_ovr [2];
  int m_len [2];
  int m_left[2];

  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_run[i] <= 1'b0; m_done[i] <= 1'b0; m_ovr[i] <= 1'b0;
        m_len[i] <= 0;    m_left[i] <= 0;
      end else if (clr) begin
        m_run[i] <= 1'b0; m_done[i] <= 1'b0; m_ovr[i] <= 1'b0;
      end else if (m_run[i]) begin
        if (start) m_ovr[i] <= 1'b1;
        if (ena) begin
          m_left[i] <= m_left[i] - 1;
          if (m_left[i] == 1) begin
            m_run[i]  <= 1'b0;
            m_done[i] <= 1'b1;
          end
        end
      end else if (m_done[i] && i == 1) begin
        m_done[i] <= 1'b0;
        m_run[i]  <= 1'b1;
        m_left[i] <= m_len[i];
      end else begin
        m_done[i] <= 1'b0;
        if (start && len != 0) begin
          m_run[i]  <= 1'b1;
          m_len[i]  <= int'(len);
          m_left[i] <= int'(len);
        end
      end
    end
  end

  function automatic int exp_out(input int i);
    int v;
    if (m_done[i])     v = m_len[i];
    else if (m_run[i]) v = m_len[i] - m_left[i];
    else               v = 0;
    return v % (1 << N);
  endfunction

  always @(negedge clk) begin
    check("out0",  int'(out0),  exp_out(0));
    check("busy0", int'(busy0), int'(m_run[0]));
    check("done0", int'(done0), int'(m_done[0]));
    check("tc0",   int'(tc0),   int'(m_run[0] && ena && m_left[0] == 1));
    check("out1",  int'(out1),  exp_out(1));
    check("busy1", int'(busy1), int'(m_run[1]));
    check("done1", int'(done1), int'(m_done[1]));
    check("tc1",   int'(tc1),   int'(m_run[1] && ena && m_left[1] == 1));
`ifdef FRAME_BIT_COUNTER_OVERRUN_EN
    check("ovr0",  int'(ovr0),  int'(m_ovr[0]));
    check("ovr1",  int'(ovr1),  int'(m_ovr[1]));
`endif
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clr();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic do_start(input int l);
    len   = N'(l);
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    tick();
    tick();
    check("rst_out", int'(out0), 0);
    check("rst_busy", int'(busy0), 0);
    rst = 1'b0;
    tick();

    // One-shot length 8, ena every third cycle.
    do_start(8);
    check("l8_busy", int'(busy0), 1);
    check("l8_out0", int'(out0), 0);
    for (int k = 0; k < 8; k++) begin
      ena = 1'b1;
      #1;
      check("l8_tc", int'(tc0), (k == 7) ? 1 : 0);
      tick();
      ena = 1'b0;
      if (k < 7) begin
        check("l8_step", int'(out0), k + 1);
      end else begin
        check("l8_done", int'(done0), 1);
        check("l8_dout", int'(out0), 8);
        check("l8_dbusy", int'(busy0), 0);
      end
      tick();
      if (k == 7) begin
        check("l8_idle_out", int'(out0), 0);
        check("l8_idle_busy", int'(busy0), 0);
        check("l8_idle_done", int'(done0), 0);
      end
      tick();
    end

    // Asynchronous reset mid-frame.
    do_clr();
    do_start(8);
    for (int k = 0; k < 3; k++) begin
      ena = 1'b1; tick(); ena = 1'b0; tick();
    end
    check("pre_rst_out", int'(out0), 3);
    #2 rst = 1'b1;
    #1;
    check("arst_out0", int'(out0), 0);
    check("arst_busy0", int'(busy0), 0);
    check("arst_out1", int'(out1), 0);
    tick();
    rst = 1'b0;
    tick();

    // Synchronous clear mid-frame, with a simultaneous ena.
    do_start(8);
    for (int k = 0; k < 3; k++) begin
      ena = 1'b1; tick(); ena = 1'b0; tick();
    end
    clr = 1'b1;
    ena = 1'b1;
    tick();
    clr = 1'b0;
    ena = 1'b0;
    check("clr_out", int'(out0), 0);
    check("clr_busy", int'(busy0), 0);
    check("clr_done", int'(done0), 0);
    tick();

    // len = 0 is ignored.
    do_start(0);
    check("l0_busy0", int'(busy0), 0);
    check("l0_busy1", int'(busy1), 0);
    tick();

    // len = 1.
    do_start(1);
    ena = 1'b1;
    #1;
    check("l1_tc", int'(tc0), 1);
    tick();
    ena = 1'b0;
    check("l1_done", int'(done0), 1);
    check("l1_out", int'(out0), 1);
    tick();
    check("l1_idle", int'(busy0), 0);
    do_clr();

    // len = 15: full range, continuous ena.
    do_start(15);
    ena = 1'b1;
    for (int k = 0; k < 15; k++) begin
      if (k == 14) check("l15_pre", int'(out0), 14);
      tick();
    end
    ena = 1'b0;
    check("l15_out", int'(out0), 15);
    check("l15_done", int'(done0), 1);
    tick();
    check("l15_idle", int'(out0), 0);
    do_clr();

    // Back-to-back: start during DONE.
    do_start(3);
    ena = 1'b1;
    repeat (3) tick();
    ena = 1'b0;
    check("b2b_done", int'(done0), 1);
    do_start(3);
    check("b2b_busy", int'(busy0), 1);
    check("b2b_out", int'(out0), 0);
    check("b2b_done0", int'(done0), 0);
    ena = 1'b1;
    repeat (3) tick();
    ena = 1'b0;
    check("b2b_end", int'(out0), 3);
    tick();
    tick();
    do_clr();

    // Continuous framing on the WRAP=1 instance: period of 5 cycles.
    do_start(4);
    ena = 1'b1;
    for (int c = 0; c < 20; c++) begin
      check("wrap_out", int'(out1), c % 5);
      check("wrap_done", int'(done1), (c % 5 == 4) ? 1 : 0);
      tick();
    end
    ena = 1'b0;
    do_clr();
    check("wrap_clr", int'(busy1), 0);

    // Start during RUN: count unaffected; overrun flag when built in.
    do_start(5);
    ena = 1'b1; tick(); ena = 1'b0;
    do_start(2);
    check("ovr_cnt", int'(out0), 1);
    check("ovr_busy", int'(busy0), 1);
`ifdef FRAME_BIT_COUNTER_OVERRUN_EN
    check("ovr_set", int'(ovr0), 1);
`endif
    ena = 1'b1;
    repeat (4) tick();
    ena = 1'b0;
    check("ovr_frame_end", int'(out0), 5);
`ifdef FRAME_BIT_COUNTER_OVERRUN_EN
    check("ovr_hold", int'(ovr0), 1);
`endif
    tick();
    do_clr();
`ifdef FRAME_BIT_COUNTER_OVERRUN_EN
    check("ovr_clr", int'(ovr0), 0);
`endif
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
